// File: rtl/serial_feeder_if.sv
// Producer-side byte write channel into serial_feeder.
// valid/ready: a byte transfers on a rising edge where wr_valid && wr_ready; wr_ready depends on occupancy only.
interface serial_feeder_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/serial_feeder.sv
// Frame-paced byte feeder for the 8-bit serial shifter: owns scnt/sclk and a byte FIFO.
// Optional sticky overflow flag enabled by defining SERIAL_FEEDER_OVF_EN.
module serial_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    serial_feeder_if.slave    wr,
    output logic [4:0]        scnt,
    output logic [7:0]        ser_data,
    output logic              ser_en,
    output logic              sclk,
    output logic              frame_done,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              ovf_flag,
    input  logic              ovf_clr
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {FRAME_IDLE = 1'b0, FRAME_DATA = 1'b1} frame_t;

    frame_t           frame_q, frame_d;
    logic [4:0]       scnt_d;
    logic [7:0]       data_d;
    logic             sclk_d;
    logic             done_d;
    logic             pop;
    logic             push;
    logic             full;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign full        = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    // The frame type register is the state; ser_en exposes it directly.
    assign ser_en      = (frame_q == FRAME_IDLE);

    always_comb begin
        scnt_d  = (scnt == 5'd19) ? 5'd0 : scnt + 5'd1;
        frame_d = frame_q;
        data_d  = ser_data;
        pop     = 1'b0;
        if (scnt == 5'd2) begin
            if (fifo_level != '0) begin
                frame_d = FRAME_DATA;
                data_d  = mem[rd_ptr];
                pop     = 1'b1;
            end else begin
                frame_d = FRAME_IDLE;
            end
        end
        // Registered sclk follows the next scnt: high on odd counts 5..19 of a data frame.
        sclk_d = (frame_q == FRAME_DATA) && scnt_d[0] && (scnt_d >= 5'd5);
        done_d = (frame_q == FRAME_DATA) && (scnt == 5'd19);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scnt       <= 5'd0;
            frame_q    <= FRAME_IDLE;
            ser_data   <= 8'h00;
            sclk       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            scnt       <= scnt_d;
            frame_q    <= frame_d;
            ser_data   <= data_d;
            sclk       <= sclk_d;
            frame_done <= done_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

`ifdef SERIAL_FEEDER_OVF_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            ovf_flag <= 1'b0;
        else if (wr.wr_valid && full)
            ovf_flag <= 1'b1;
        else if (ovf_clr)
            ovf_flag <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_flag       = 1'b0;
`endif
endmodule

// File: tb/tb_serial_feeder.sv
// Randomized scoreboard bench for serial_feeder against a frame-level reference model.
module tb_serial_feeder;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [4:0]       scnt;
    logic [7:0]       ser_data;
    logic             ser_en;
    logic             sclk;
    logic             frame_done;
    logic [LVL_W-1:0] fifo_level;
    logic             ovf_flag;
    logic             ovf_clr;

    serial_feeder_if wr_bus ();

    serial_feeder #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr         (wr_bus),
        .scnt       (scnt),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .sclk       (sclk),
        .frame_done (frame_done),
        .fifo_level (fifo_level),
        .ovf_flag   (ovf_flag),
        .ovf_clr    (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: frame position, queued bytes, current frame contents.
    int         m_cnt;
    logic [7:0] m_fifo[$];
    bit         m_frame;
    bit         m_fd;
    bit         m_ovf;
    logic [7:0] m_data;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                m_cnt = 0; m_fifo.delete(); exp_q.delete();
                m_frame = 0; m_fd = 0; m_ovf = 0; m_data = 8'h00;
            end else begin
                automatic bit was_full = (m_fifo.size() == DEPTH);
                automatic bit accept   = wr_bus.wr_valid && !was_full;
                m_fd = (m_cnt == 19) && m_frame;
                if (m_cnt == 2) begin
                    if (m_fifo.size() > 0) begin
                        m_frame = 1;
                        m_data  = m_fifo.pop_front();
                    end else begin
                        m_frame = 0;
                    end
                end
                if (accept) begin
                    m_fifo.push_back(wr_bus.wr_data);
                    exp_q.push_back(wr_bus.wr_data);
                end
`ifdef SERIAL_FEEDER_OVF_EN
                if (wr_bus.wr_valid && was_full) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
`endif
                m_cnt = (m_cnt + 1) % 20;
            end
        end
    end

    // Monitor: per-cycle outputs against the model, bytes against the scoreboard.
    initial begin
        forever begin
            @(negedge sys_clk);
            check("scnt", 32'(scnt), 32'(m_cnt));
            check("ser_en", 32'(ser_en), 32'(!m_frame));
            check("ser_data", 32'(ser_data), 32'(m_data));
            check("sclk", 32'(sclk), 32'(m_frame && (m_cnt % 2 == 1) && m_cnt >= 5));
            check("frame_done", 32'(frame_done), 32'(m_fd));
            check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
            check("wr_ready", 32'(wr_bus.wr_ready), 32'(m_fifo.size() < DEPTH));
            check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
            if (!sys_rst && scnt == 5'd3 && ser_en == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: got byte 0x%0h expected none at %0t", ser_data, $time);
                end else begin
                    check("sb_byte", 32'(ser_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 40) begin
            step(1);
            k++;
        end
        if (m_cnt != target) begin
            n_chk++;
            $display("FAIL wait_cnt: got %0d expected %0d", m_cnt, target);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = d;
        step(1);
        wr_bus.wr_valid = 1'b0;
    endtask

    initial begin
        sys_rst         = 1'b1;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = 8'h00;
        ovf_clr         = 1'b0;
        step(3);
        sys_rst = 1'b0;
        step(60);

        wait_cnt(0);
        push(8'hA5);
        step(45);

        wait_cnt(5);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_cnt(2);
        push(8'h55);
        step(10);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(100);

        wait_cnt(0);
        push(8'hC1); push(8'hC2); push(8'hC3);
        wait_cnt(10);
        sys_rst = 1'b1;
        step(2);
        sys_rst = 1'b0;
        step(40);

        wait_cnt(2);
        push(8'h80);
        step(45);

        repeat (400) begin
            wr_bus.wr_valid = ($urandom_range(0, 5) == 0);
            wr_bus.wr_data  = 8'($urandom);
            ovf_clr         = ($urandom_range(0, 30) == 0);
            step(1);
        end
        wr_bus.wr_valid = 1'b0;
        ovf_clr         = 1'b0;
        step(120);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
